// File: rtl/spi_flash_responder.sv
// spi_flash_responder: oversampled SPI mode-0 NOR flash target serving READ (0x03) and JEDEC ID (0x9F)
module spi_flash_responder #(
  parameter int          ADDR_W   = 16,
  parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, FETCH, DATA, ID, IGNORE} state_t;
  state_t state, state_nxt;
  logic sclk_m, sclk_s, sclk_d, cs_m, cs_s, mosi_m, mosi_s;
  logic rise, fall, cap, streaming, load, hdr_done;
  logic [22:0] rx_sr;
  logic [23:0] rx_nxt;
  logic [6:0] tx_sr;
  logic [7:0] nxt_byte, load_byte;
  logic [4:0] bit_cnt;
  logic [1:0] id_idx;
  logic [ADDR_W-1:0] addr;
  logic unused_addr_hi;
  assign rise = sclk_s & ~sclk_d & ~cs_s;
  assign fall = ~sclk_s & sclk_d & ~cs_s;
  assign rx_nxt = {rx_sr, mosi_s};
  assign unused_addr_hi = ^rx_nxt[23:ADDR_W];
  assign streaming = state == DATA || state == ID;
  assign load = fall && streaming && bit_cnt[2:0] == 3'd0;
  assign hdr_done = (state == CMD && bit_cnt == 5'd7) || (state == ADDR && bit_cnt == 5'd23);
  assign load_byte = state == DATA ? nxt_byte :
                     id_idx == 2'd0 ? JEDEC_ID[23:16] :
                     id_idx == 2'd1 ? JEDEC_ID[15:8] : JEDEC_ID[7:0];
  // two-flop synchronisers for the async pins, plus sclk history for edge detection
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) {cs_m, cs_s, sclk_m, sclk_s, sclk_d, mosi_m, mosi_s} <= 7'b1100000;
    else {cs_m, cs_s, sclk_m, sclk_s, sclk_d, mosi_m, mosi_s} <= {cs_n, cs_m, sclk, sclk_m, sclk_s, mosi, mosi_m};
  // state register
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_nxt;
  // next state: CS high always returns to IDLE, otherwise opcode/address progress
  always_comb begin
    state_nxt = state;
    if (cs_s) state_nxt = IDLE;
    else case (state)
      IDLE:    state_nxt = CMD;
      CMD:     if (rise && hdr_done) state_nxt = rx_nxt[7:0] == 8'h03 ? ADDR : rx_nxt[7:0] == 8'h9F ? ID : IGNORE;
      ADDR:    if (rise && hdr_done) state_nxt = FETCH;
      FETCH:   if (cap) state_nxt = DATA;
      default: state_nxt = state;
    endcase
  end
  // shift registers, byte loads and memory prefetch; CS high discards everything in flight
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      miso <= 1'b0;
      mem_en <= 1'b0;
      mem_addr <= '0;
      busy <= 1'b0;
      cap <= 1'b0;
      rx_sr <= '0;
      tx_sr <= '0;
      nxt_byte <= '0;
      bit_cnt <= '0;
      id_idx <= '0;
      addr <= '0;
    end else if (cs_s) begin
      miso <= 1'b0;
      mem_en <= 1'b0;
      busy <= 1'b0;
      cap <= 1'b0;
      rx_sr <= '0;
      tx_sr <= '0;
      nxt_byte <= '0;
      bit_cnt <= '0;
      id_idx <= '0;
      addr <= '0;
    end else begin
      busy <= 1'b1;
      mem_en <= 1'b0;
      cap <= mem_en;
      if (cap) nxt_byte <= mem_rdata;
      if (rise) begin
        rx_sr <= rx_nxt[22:0];
        bit_cnt <= hdr_done ? 5'd0 : bit_cnt + 5'd1;
      end
      if (rise && state == ADDR && hdr_done) begin
        mem_en <= 1'b1;
        mem_addr <= rx_nxt[ADDR_W-1:0];
        addr <= rx_nxt[ADDR_W-1:0];
      end
      if (fall && streaming) begin
        tx_sr <= load ? load_byte[6:0] : {tx_sr[5:0], 1'b0};
        miso <= load ? load_byte[7] : tx_sr[6];
      end
      if (load && state == DATA) begin
        mem_en <= 1'b1;
        mem_addr <= addr + 1'b1;
        addr <= addr + 1'b1;
      end
      if (load && state == ID) id_idx <= id_idx == 2'd2 ? 2'd0 : id_idx + 2'd1;
    end
endmodule

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder: randomized SPI initiator against a byte-stream reference model of the flash
module tb_spi_flash_responder;
  localparam int H = 8;
  localparam logic [23:0] JID = 24'hEF4016;
  logic clk = 1'b0, resetn = 1'b0, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic miso, mem_en, busy;
  logic [15:0] mem_addr;
  logic [7:0] mem_rdata = 8'h00;
  logic [7:0] mem [0:65535];
  logic [15:0] fetch_q[$];
  logic prev_en = 1'b0;
  int checks = 0, errors = 0, consec = 0;
  always #5 clk = ~clk;
  spi_flash_responder dut (
    .clk(clk), .resetn(resetn), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .busy(busy)
  );
  // synchronous byte memory with one cycle of read latency
  always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];
  // log every memory strobe and count back-to-back strobes
  always @(negedge clk) begin
    if (mem_en && prev_en) consec++;
    prev_en = mem_en;
    if (mem_en) fetch_q.push_back(mem_addr);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic cs_low();
    fetch_q.delete();
    cs_n = 1'b0;
    wait_clk(H);
  endtask
  task automatic cs_high();
    wait_clk(H);
    cs_n = 1'b1;
    wait_clk(10);
  endtask
  task automatic shift(input logic [63:0] data, input int n, output logic [63:0] rx);
    rx = '0;
    for (int i = n - 1; i >= 0; i--) begin
      mosi = data[i];
      wait_clk(H);
      rx = {rx[62:0], miso};
      sclk = 1'b1;
      wait_clk(H);
      sclk = 1'b0;
    end
  endtask
  // every clocked byte (plus the one loaded by the trailing fall) triggers one prefetch beyond the initial fetch
  task automatic do_read(input logic [23:0] a, input int n);
    logic [63:0] rx;
    logic [15:0] base;
    base = a[15:0];
    cs_low();
    shift({32'd0, 8'h03, a}, 32, rx);
    check("rd_hdr_miso", rx[31:0], 32'd0);
    shift(64'd0, 8 * n, rx);
    check("rd_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < n; i++) check("rd_byte", {24'd0, rx[8 * (n - 1 - i) +: 8]}, {24'd0, mem[16'(base + i)]});
    cs_high();
    check("rd_nfetch", fetch_q.size(), n + 2);
    for (int i = 0; i < fetch_q.size(); i++) check("rd_addr", {16'd0, fetch_q[i]}, {16'd0, 16'(base + i)});
    check("busy_idle", {31'd0, busy}, 32'd0);
    check("mem_en_consec", consec, 0);
  endtask
  initial begin
    logic [63:0] rx;
    logic [31:0] r;
    logic [7:0] id_b [3];
    id_b[0] = JID[23:16];
    id_b[1] = JID[15:8];
    id_b[2] = JID[7:0];
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    wait_clk(3);
    check("rst_miso", {31'd0, miso}, 32'd0);
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    resetn = 1'b1;
    wait_clk(5);
    mem[16'h0010] = 8'h11;
    mem[16'h0011] = 8'h22;
    mem[16'h0012] = 8'h33;
    mem[16'h0013] = 8'h44;
    do_read(24'h000010, 4);
    mem[16'hFFFF] = 8'hAA;
    mem[16'h0000] = 8'h55;
    do_read(24'h00FFFF, 2);
    cs_low();
    shift(64'h9F, 8, rx);
    check("id_hdr_miso", rx[31:0], 32'd0);
    shift(64'd0, 48, rx);
    for (int i = 0; i < 6; i++) check("id_byte", {24'd0, rx[8 * (5 - i) +: 8]}, {24'd0, id_b[i % 3]});
    cs_high();
    check("id_nfetch", fetch_q.size(), 0);
    cs_low();
    shift(64'h05, 8, rx);
    r = $urandom;
    shift({48'd0, r[15:0]}, 16, rx);
    check("ign_miso", rx[31:0], 32'd0);
    check("ign_busy", {31'd0, busy}, 32'd1);
    cs_high();
    check("ign_busy_end", {31'd0, busy}, 32'd0);
    check("ign_nfetch", fetch_q.size(), 0);
    cs_low();
    shift(64'h03, 8, rx);
    shift(64'h0FF, 12, rx);
    cs_high();
    check("abort_nfetch", fetch_q.size(), 0);
    do_read(24'h000002, 1);
    mem[16'h0402] = 8'hFF;
    cs_low();
    shift({32'd0, 8'h03, 24'h000400}, 32, rx);
    shift(64'd0, 16, rx);
    check("rr_byte0", {24'd0, rx[15:8]}, {24'd0, mem[16'h0400]});
    check("rr_byte1", {24'd0, rx[7:0]}, {24'd0, mem[16'h0401]});
    shift(64'd0, 3, rx);
    wait_clk(H);
    check("rr_pre_miso", {31'd0, miso}, 32'd1);
    check("rr_pre_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("rr_miso", {31'd0, miso}, 32'd0);
    check("rr_busy", {31'd0, busy}, 32'd0);
    check("rr_mem_en", {31'd0, mem_en}, 32'd0);
    cs_n = 1'b1;
    wait_clk(4);
    resetn = 1'b1;
    wait_clk(10);
    do_read(24'h000400, 3);
    for (int k = 0; k < 8; k++) begin
      r = $urandom;
      do_read(r[23:0], int'($urandom_range(1, 5)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
